// File: rtl/trace_stream_sink_pkg.sv
// trace_stream_sink_pkg
//   Definitions shared by the trace stream sink and the trace producer.
//   - WFI_INSTRUCTION: encoding of RISC-V WFI. A frame may close early on it.
//   - rb_addr_e: ctrl readback address map.
//   - INSTR_LSB / PC_LSB: field offsets inside a {pc, instr} packet.
//   - sat_inc16: 16-bit saturating increment used by the error counter.
package trace_stream_sink_pkg;

    localparam logic [31:0] WFI_INSTRUCTION = 32'h1050_0073;

    localparam int INSTR_LSB = 0;
    localparam int PC_LSB    = 32;

    typedef enum logic [2:0] {
        RB_BEAT_COUNT      = 3'd0,
        RB_FRAME_COUNT     = 3'd1,
        RB_INTERVAL_ERRORS = 3'd2,
        RB_LEVEL           = 3'd3,
        RB_WFI_SEEN        = 3'd4,
        RB_STALL_COUNT     = 3'd5
    } rb_addr_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            return value;
        end else begin
            return value + 16'd1;
        end
    endfunction

endpackage

// File: rtl/trace_stream_sink_if.sv
// trace_stream_sink_if
//   AXI-Stream link that carries {pc, instr} trace packets.
//   master: drives tvalid/tdata/tlast and samples tready.
//   slave : samples tvalid/tdata/tlast and drives tready.
interface trace_stream_sink_if #(
    parameter int DATA_WIDTH = 96
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/trace_sink_fifo.sv
// trace_sink_fifo
//   Parameterised first-word-fall-through synchronous FIFO.
//   Ports: clk, rst_n (sync, active-low); push_i/push_data_i write side;
//   pop_i/pop_data_o read side (the head entry is visible whenever it is
//   not empty); full_o, empty_o, level_o status.
//   A push while full is ignored, and so is a pop while empty.
//   pop_data_o reads zero while the FIFO is empty.
module trace_sink_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 97
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           pop_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] LEVEL_FULL = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   level_q;
    logic [PTR_W:0]   level_d;
    logic             push_s;
    logic             pop_s;

    assign full_o     = (level_q == LEVEL_FULL);
    assign empty_o    = (level_q == {(PTR_W+1){1'b0}});
    assign level_o    = level_q;
    assign push_s     = push_i & ~full_o;
    assign pop_s      = pop_i & ~empty_o;
    assign pop_data_o = empty_o ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];

    // Level bookkeeping: a simultaneous push and pop leaves it unchanged.
    always_comb begin
        level_d = level_q;
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + (PTR_W+1)'(1);
            2'b01:   level_d = level_q - (PTR_W+1)'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and level registers; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            level_q  <= {(PTR_W+1){1'b0}};
        end else begin
            level_q <= level_d;
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Storage array; contents need no reset because empty_o gates the read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/trace_stream_sink.sv
// trace_stream_sink
//   AXI-Stream consumer for {pc, instr} trace packets. Buffers beats in an
//   FWFT FIFO, presents them on a pc/instr read port, and keeps statistics.
//   Ports: clk, rst_n (sync, active-low); s_axis (slave modport: tvalid,
//   tready, tdata = {pc, instr}, tlast); tlast_interval_i (expected beats per
//   frame, 0 disables the framing check); rd_valid_o/rd_ready_i/rd_pc_o/
//   rd_instr_o/rd_last_o head-of-FIFO port; ctrl_addr_i/ctrl_rdata_o
//   registered readback; stats_clear_i level-sensitive statistics clear.
//   Optional build macro TRACE_STREAM_SINK_STALL_COUNT_EN adds a stall
//   counter at readback address 5; without it, address 5 reads 0.
module trace_stream_sink
    import trace_stream_sink_pkg::*;
#(
    parameter int XLEN            = 64,
    parameter int AXI_DATA_WIDTH  = XLEN + 32,
    parameter int FIFO_DEPTH      = 16,
    parameter int CTRL_ADDR_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    trace_stream_sink_if.slave         s_axis,
    input  logic [31:0]                tlast_interval_i,
    output logic                       rd_valid_o,
    input  logic                       rd_ready_i,
    output logic [XLEN-1:0]            rd_pc_o,
    output logic [31:0]                rd_instr_o,
    output logic                       rd_last_o,
    input  logic [CTRL_ADDR_WIDTH-1:0] ctrl_addr_i,
    output logic [63:0]                ctrl_rdata_o,
    input  logic                       stats_clear_i
);
    localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_W = AXI_DATA_WIDTH + 1;

    logic               ready_en_q;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic [LEVEL_W-1:0] fifo_level_s;
    logic [ENTRY_W-1:0] head_s;
    logic               accept_s;
    logic [31:0]        beat_instr_s;
    logic [31:0]        pos_inc_s;
    logic               check_en_s;
    logic [31:0]        stall_value_s;

    logic [31:0] beat_q, beat_d;
    logic [31:0] frame_q, frame_d;
    logic [31:0] pos_q, pos_d;
    logic [15:0] err_q, err_d;
    logic        wfi_q, wfi_d;
    logic [63:0] rdata_q, rdata_d;

    // Holds tready low while reset is asserted and for its duration only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
        end
    end

    assign s_axis.tready = ready_en_q & ~fifo_full_s;
    assign accept_s      = s_axis.tvalid & s_axis.tready;
    assign beat_instr_s  = s_axis.tdata[INSTR_LSB +: 32];
    assign pos_inc_s     = pos_q + 32'd1;
    assign check_en_s    = (tlast_interval_i != 32'd0);

    trace_sink_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (accept_s),
        .push_data_i ({s_axis.tlast, s_axis.tdata}),
        .pop_i       (rd_ready_i),
        .pop_data_o  (head_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s),
        .level_o     (fifo_level_s)
    );

    assign rd_valid_o = ~fifo_empty_s;
    assign rd_pc_o    = head_s[PC_LSB +: XLEN];
    assign rd_instr_o = head_s[INSTR_LSB +: 32];
    assign rd_last_o  = head_s[AXI_DATA_WIDTH];

    // Statistics and framing check; clear takes priority over an accept.
    always_comb begin
        beat_d  = beat_q;
        frame_d = frame_q;
        pos_d   = pos_q;
        err_d   = err_q;
        wfi_d   = wfi_q;
        if (stats_clear_i) begin
            beat_d  = 32'd0;
            frame_d = 32'd0;
            pos_d   = 32'd0;
            err_d   = 16'd0;
            wfi_d   = 1'b0;
        end else if (accept_s) begin
            beat_d = beat_q + 32'd1;
            if (beat_instr_s == WFI_INSTRUCTION) begin
                wfi_d = 1'b1;
            end else begin
                wfi_d = wfi_q;
            end
            if (s_axis.tlast) begin
                frame_d = frame_q + 32'd1;
                pos_d   = 32'd0;
                // A WFI may legitimately end a frame short.
                if (check_en_s && (pos_inc_s != tlast_interval_i) &&
                    (beat_instr_s != WFI_INSTRUCTION)) begin
                    err_d = sat_inc16(err_q);
                end else begin
                    err_d = err_q;
                end
            end else begin
                // Missing tlast: flag it and resynchronise to a new frame.
                if (check_en_s && (pos_inc_s == tlast_interval_i)) begin
                    err_d = sat_inc16(err_q);
                    pos_d = 32'd0;
                end else begin
                    pos_d = pos_inc_s;
                end
            end
        end else begin
            beat_d = beat_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_q  <= 32'd0;
            frame_q <= 32'd0;
            pos_q   <= 32'd0;
            err_q   <= 16'd0;
            wfi_q   <= 1'b0;
        end else begin
            beat_q  <= beat_d;
            frame_q <= frame_d;
            pos_q   <= pos_d;
            err_q   <= err_d;
            wfi_q   <= wfi_d;
        end
    end

`ifdef TRACE_STREAM_SINK_STALL_COUNT_EN
    logic [31:0] stall_q;

    // Counts cycles where the producer offers a beat the sink cannot take.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= 32'd0;
        end else if (stats_clear_i) begin
            stall_q <= 32'd0;
        end else if (s_axis.tvalid & ~s_axis.tready) begin
            stall_q <= stall_q + 32'd1;
        end else begin
            stall_q <= stall_q;
        end
    end

    assign stall_value_s = stall_q;
`else
    assign stall_value_s = 32'd0;
`endif

    // Readback address decode.
    always_comb begin
        rdata_d = 64'd0;
        case (ctrl_addr_i)
            CTRL_ADDR_WIDTH'(RB_BEAT_COUNT):      rdata_d = {32'd0, beat_q};
            CTRL_ADDR_WIDTH'(RB_FRAME_COUNT):     rdata_d = {32'd0, frame_q};
            CTRL_ADDR_WIDTH'(RB_INTERVAL_ERRORS): rdata_d = {48'd0, err_q};
            CTRL_ADDR_WIDTH'(RB_LEVEL):           rdata_d = 64'(fifo_level_s);
            CTRL_ADDR_WIDTH'(RB_WFI_SEEN):        rdata_d = {63'd0, wfi_q};
            CTRL_ADDR_WIDTH'(RB_STALL_COUNT):     rdata_d = {32'd0, stall_value_s};
            default:                              rdata_d = 64'd0;
        endcase
    end

    // Registered readback data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= 64'd0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign ctrl_rdata_o = rdata_q;

endmodule

// File: tb/tb_trace_stream_sink.sv
module tb_trace_stream_sink;

    localparam logic [31:0] WFI = 32'h1050_0073;
    localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef TRACE_STREAM_SINK_STALL_COUNT_EN
    localparam logic [63:0] STALL_AFTER_FILL = 64'd4;
    localparam logic [63:0] STALL_AFTER_POP  = 64'd5;
`else
    localparam logic [63:0] STALL_AFTER_FILL = 64'd0;
    localparam logic [63:0] STALL_AFTER_POP  = 64'd0;
`endif

    typedef struct {
        logic [31:0] interval;
        logic [31:0] instr;
        logic        last;
        logic [15:0] exp_err;
        logic [31:0] exp_frames;
        logic        exp_wfi;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] tlast_interval;
    logic        rd_valid;
    logic        rd_ready;
    logic [63:0] rd_pc;
    logic [31:0] rd_instr;
    logic        rd_last;
    logic [7:0]  ctrl_addr;
    logic [63:0] ctrl_rdata;
    logic        stats_clear;
    logic [63:0] rb_val;

    int checks = 0;
    int errors = 0;

    vec_t vecs [18];

    always #5 clk = ~clk;

    trace_stream_sink_if #(.DATA_WIDTH(96)) axis_if ();

    trace_stream_sink dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .s_axis           (axis_if),
        .tlast_interval_i (tlast_interval),
        .rd_valid_o       (rd_valid),
        .rd_ready_i       (rd_ready),
        .rd_pc_o          (rd_pc),
        .rd_instr_o       (rd_instr),
        .rd_last_o        (rd_last),
        .ctrl_addr_i      (ctrl_addr),
        .ctrl_rdata_o     (ctrl_rdata),
        .stats_clear_i    (stats_clear)
    );

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rb(input logic [7:0] addr, output logic [63:0] val);
        ctrl_addr = addr;
        tick();
        val = ctrl_rdata;
    endtask

    task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] instr, input logic last);
        axis_if.tvalid = v;
        axis_if.tdata  = {pc, instr};
        axis_if.tlast  = last;
    endtask

    initial begin
        //           interval instr last  err    frames  wfi
        vecs[0]  = '{32'd3, NOP, 1'b0, 16'd0, 32'd0, 1'b0};
        vecs[1]  = '{32'd3, NOP, 1'b0, 16'd0, 32'd0, 1'b0};
        vecs[2]  = '{32'd3, NOP, 1'b1, 16'd0, 32'd1, 1'b0};
        vecs[3]  = '{32'd4, NOP, 1'b0, 16'd0, 32'd1, 1'b0};
        vecs[4]  = '{32'd4, NOP, 1'b1, 16'd1, 32'd2, 1'b0};
        vecs[5]  = '{32'd4, NOP, 1'b0, 16'd1, 32'd2, 1'b0};
        vecs[6]  = '{32'd4, WFI, 1'b1, 16'd1, 32'd3, 1'b1};
        vecs[7]  = '{32'd4, NOP, 1'b0, 16'd1, 32'd3, 1'b1};
        vecs[8]  = '{32'd4, NOP, 1'b0, 16'd1, 32'd3, 1'b1};
        vecs[9]  = '{32'd4, NOP, 1'b0, 16'd1, 32'd3, 1'b1};
        vecs[10] = '{32'd4, NOP, 1'b0, 16'd2, 32'd3, 1'b1};
        vecs[11] = '{32'd4, NOP, 1'b0, 16'd2, 32'd3, 1'b1};
        vecs[12] = '{32'd4, NOP, 1'b0, 16'd2, 32'd3, 1'b1};
        vecs[13] = '{32'd4, NOP, 1'b0, 16'd2, 32'd3, 1'b1};
        vecs[14] = '{32'd4, NOP, 1'b1, 16'd2, 32'd4, 1'b1};
        vecs[15] = '{32'd0, NOP, 1'b1, 16'd2, 32'd5, 1'b1};
        vecs[16] = '{32'd1, NOP, 1'b1, 16'd2, 32'd6, 1'b1};
        vecs[17] = '{32'd1, NOP, 1'b0, 16'd3, 32'd6, 1'b1};

        rst_n          = 1'b0;
        tlast_interval = 32'd0;
        rd_ready       = 1'b0;
        ctrl_addr      = 8'd0;
        stats_clear    = 1'b0;
        drive(1'b0, 64'd0, 32'd0, 1'b0);

        // Reset state
        tick();
        tick();
        chk("reset_tready", 64'(axis_if.tready), 64'd0);
        chk("reset_rd_valid", 64'(rd_valid), 64'd0);
        chk("reset_rd_pc", rd_pc, 64'd0);
        chk("reset_rd_instr", 64'(rd_instr), 64'd0);
        chk("reset_rd_last", 64'(rd_last), 64'd0);
        chk("reset_ctrl_rdata", ctrl_rdata, 64'd0);
        rst_n = 1'b1;
        tick();
        chk("post_reset_tready", 64'(axis_if.tready), 64'd1);

        // Table: one beat per record, head port and stats checked after each
        rd_ready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            tlast_interval = vecs[i].interval;
            drive(1'b1, 64'h8000_0000 + 64'(4 * i), vecs[i].instr, vecs[i].last);
            tick();
            drive(1'b0, 64'd0, 32'd0, 1'b0);
            chk("tbl_rd_valid", 64'(rd_valid), 64'd1);
            chk("tbl_rd_pc", rd_pc, 64'h8000_0000 + 64'(4 * i));
            chk("tbl_rd_instr", 64'(rd_instr), 64'(vecs[i].instr));
            chk("tbl_rd_last", 64'(rd_last), 64'(vecs[i].last));
            rb(8'd2, rb_val);
            chk("tbl_interval_errors", rb_val, 64'(vecs[i].exp_err));
            rb(8'd1, rb_val);
            chk("tbl_frame_count", rb_val, 64'(vecs[i].exp_frames));
            rb(8'd4, rb_val);
            chk("tbl_wfi_seen", rb_val, 64'(vecs[i].exp_wfi));
        end
        rb(8'd0, rb_val);
        chk("tbl_beat_count", rb_val, 64'd18);
        rb(8'd7, rb_val);
        chk("unmapped_addr", rb_val, 64'd0);

        // Fill to full with no consumer: 16 accepts then 4 stall cycles
        stats_clear = 1'b1;
        tick();
        stats_clear = 1'b0;
        rd_ready = 1'b0;
        tlast_interval = 32'd0;
        for (int c = 0; c < 20; c++) begin
            drive(1'b1, 64'h1000 + 64'(4 * c), NOP, 1'b0);
            chk("fill_tready", 64'(axis_if.tready), 64'(c < 16));
            tick();
        end
        drive(1'b0, 64'd0, 32'd0, 1'b0);
        rb(8'd3, rb_val);
        chk("full_level", rb_val, 64'd16);
        chk("full_tready", 64'(axis_if.tready), 64'd0);
        rb(8'd5, rb_val);
        chk("fill_stall_count", rb_val, STALL_AFTER_FILL);

        // Pop with a beat offered while full: nothing is accepted
        drive(1'b1, 64'hDEAD_0000, NOP, 1'b0);
        rd_ready = 1'b1;
        chk("full_head_pc", rd_pc, 64'h1000);
        chk("full_pop_tready", 64'(axis_if.tready), 64'd0);
        tick();
        drive(1'b0, 64'd0, 32'd0, 1'b0);
        rd_ready = 1'b0;
        chk("after_pop_tready", 64'(axis_if.tready), 64'd1);
        rb(8'd3, rb_val);
        chk("after_pop_level", rb_val, 64'd15);
        rb(8'd5, rb_val);
        chk("pop_stall_count", rb_val, STALL_AFTER_POP);
        rd_ready = 1'b1;
        for (int k = 1; k < 16; k++) begin
            chk("drain_rd_valid", 64'(rd_valid), 64'd1);
            chk("drain_rd_pc", rd_pc, 64'h1000 + 64'(4 * k));
            tick();
        end
        chk("drained_rd_valid", 64'(rd_valid), 64'd0);
        rd_ready = 1'b0;

        // Clear during an accept: stats zero, beat still delivered
        drive(1'b1, 64'h2222_0000, WFI, 1'b0);
        stats_clear = 1'b1;
        tick();
        stats_clear = 1'b0;
        drive(1'b0, 64'd0, 32'd0, 1'b0);
        chk("clear_rd_valid", 64'(rd_valid), 64'd1);
        chk("clear_rd_pc", rd_pc, 64'h2222_0000);
        chk("clear_rd_instr", 64'(rd_instr), 64'(WFI));
        rb(8'd0, rb_val);
        chk("clear_beat_count", rb_val, 64'd0);
        rb(8'd4, rb_val);
        chk("clear_wfi_seen", rb_val, 64'd0);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk("clear_drained", 64'(rd_valid), 64'd0);

        // Reset mid-frame with beats buffered
        tlast_interval = 32'd3;
        drive(1'b1, 64'h3000, NOP, 1'b0);
        tick();
        drive(1'b1, 64'h3004, NOP, 1'b0);
        tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_rd_valid", 64'(rd_valid), 64'd0);
        chk("midrst_tready", 64'(axis_if.tready), 64'd0);
        chk("midrst_rd_pc", rd_pc, 64'd0);
        chk("midrst_ctrl_rdata", ctrl_rdata, 64'd0);
        tick();
        rst_n = 1'b1;
        drive(1'b0, 64'd0, 32'd0, 1'b0);
        tick();
        chk("midrst_post_tready", 64'(axis_if.tready), 64'd1);
        rb(8'd3, rb_val);
        chk("midrst_level", rb_val, 64'd0);
        rb(8'd0, rb_val);
        chk("midrst_beat_count", rb_val, 64'd0);

        // Fresh 3-beat frame after reset: frame position restarted at 0
        rd_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            drive(1'b1, 64'h8000_0000 + 64'(4 * j), NOP, (j == 2));
            tick();
            chk("stream_rd_pc", rd_pc, 64'h8000_0000 + 64'(4 * j));
            chk("stream_rd_last", 64'(rd_last), 64'(j == 2));
        end
        drive(1'b0, 64'd0, 32'd0, 1'b0);
        tick();
        rb(8'd2, rb_val);
        chk("stream_interval_errors", rb_val, 64'd0);
        rb(8'd1, rb_val);
        chk("stream_frame_count", rb_val, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
